// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, redirect
// source encoding (ordered by priority) and the default drain length.
package fetch_ctrl_pkg;

  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ISSUE = 2'd3
  } state_e;

  // Numeric order doubles as priority order: EX > CSR > ID > NONE.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ID   = 2'd1,
    SRC_CSR  = 2'd2,
    SRC_EX   = 2'd3
  } src_e;

  typedef struct packed {
    src_e        src;
    logic [31:0] pc;
  } redir_t;

endpackage

// File: rtl/redirect_arb.sv
// Combinational priority pick among the three redirect sources.
module redirect_arb
  import fetch_ctrl_pkg::*;
(
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        csr_valid,
  input  logic [31:0] csr_pc,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  output redir_t      req
);

  always_comb begin
    req = '{src: SRC_NONE, pc: 32'd0};
    if (ex_valid)       req = '{src: SRC_EX,  pc: ex_pc};
    else if (csr_valid) req = '{src: SRC_CSR, pc: csr_pc};
    else if (id_valid)  req = '{src: SRC_ID,  pc: id_pc};
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch redirect controller: turns EX/ID/CSR redirects, load-use bubbles and
// imem stalls into registered fetch controls. CSR redirects drain first.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_redirect_valid,
  input  logic [31:0] ex_redirect_pc,
  input  logic        id_redirect_valid,
  input  logic [31:0] id_redirect_pc,
  input  logic        csr_redirect_valid,
  input  logic [31:0] csr_redirect_pc,
  input  logic        load_use_hazard,
  input  logic        imem_stall,
  output logic        keep,
  output logic        nop,
  output logic        branch_PC_contral,
  output logic [31:0] branch_PC,
  output logic        branch_PC_early_contral,
  output logic [31:0] branch_PC_early,
  output logic        csr_PC_contral,
  output logic [31:0] csr_PC,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [15:0] redirect_count
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cpc_q, cpc_d;
  redir_t      pend_q, pend_d;
  redir_t      arb_req, eff;

  logic        keep_q, keep_d, nop_q, nop_d, fid_q, fid_d, fex_q, fex_d;
  logic        bc_q, bc_d, bec_q, bec_d, cc_q, cc_d;
  logic [31:0] bpc_q, bpc_d, bepc_q, bepc_d, cspc_q, cspc_d;
  logic [15:0] cnt16_q, cnt16_d;

  redirect_arb u_arb (
    .ex_valid  (ex_redirect_valid),
    .ex_pc     (ex_redirect_pc),
    .csr_valid (csr_redirect_valid),
    .csr_pc    (csr_redirect_pc),
    .id_valid  (id_redirect_valid),
    .id_pc     (id_redirect_pc),
    .req       (arb_req)
  );

  // Merge a held redirect with this cycle's arrival; ties go to the newer one.
  assign eff = (arb_req.src >= pend_q.src) ? arb_req : pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cpc_d   = cpc_q;
    pend_d  = pend_q;
    keep_d  = 1'b0;
    nop_d   = 1'b0;
    fid_d   = 1'b0;
    fex_d   = 1'b0;
    bc_d    = 1'b0;
    bec_d   = 1'b0;
    cc_d    = 1'b0;
    bpc_d   = 32'd0;
    bepc_d  = 32'd0;
    cspc_d  = 32'd0;
    unique case (state_q)
      ST_RUN, ST_HOLD, ST_ISSUE: begin
        if (imem_stall) begin
          keep_d  = 1'b1;
          state_d = ST_HOLD;
          pend_d  = eff;
        end else begin
          state_d = ST_RUN;
          pend_d  = '{src: SRC_NONE, pc: 32'd0};
          unique case (eff.src)
            SRC_EX: begin
              bc_d  = 1'b1;
              bpc_d = eff.pc;
              nop_d = 1'b1;
              fid_d = 1'b1;
              fex_d = 1'b1;
            end
            SRC_CSR: begin
              state_d = ST_DRAIN;
              cnt_d   = 4'(DRAIN_CYCLES - 1);
              cpc_d   = eff.pc;
              nop_d   = 1'b1;
            end
            SRC_ID: begin
              bec_d  = 1'b1;
              bepc_d = eff.pc;
              nop_d  = 1'b1;
              fid_d  = 1'b1;
            end
            default: nop_d = load_use_hazard;
          endcase
        end
      end
      ST_DRAIN: begin
        // New requests are dropped here; the trap source is older than all of them.
        if (imem_stall) begin
          keep_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_ISSUE;
          cc_d    = 1'b1;
          cspc_d  = cpc_q;
          nop_d   = 1'b1;
          fid_d   = 1'b1;
          fex_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          nop_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    cnt16_d = cnt16_q + 16'(bc_d | bec_d | cc_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      cpc_q   <= 32'd0;
      pend_q  <= '{src: SRC_NONE, pc: 32'd0};
      keep_q  <= 1'b0;
      nop_q   <= 1'b0;
      fid_q   <= 1'b0;
      fex_q   <= 1'b0;
      bc_q    <= 1'b0;
      bec_q   <= 1'b0;
      cc_q    <= 1'b0;
      bpc_q   <= 32'd0;
      bepc_q  <= 32'd0;
      cspc_q  <= 32'd0;
      cnt16_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpc_q   <= cpc_d;
      pend_q  <= pend_d;
      keep_q  <= keep_d;
      nop_q   <= nop_d;
      fid_q   <= fid_d;
      fex_q   <= fex_d;
      bc_q    <= bc_d;
      bec_q   <= bec_d;
      cc_q    <= cc_d;
      bpc_q   <= bpc_d;
      bepc_q  <= bepc_d;
      cspc_q  <= cspc_d;
      cnt16_q <= cnt16_d;
    end
  end

  assign keep                    = keep_q;
  assign nop                     = nop_q;
  assign flush_id                = fid_q;
  assign flush_ex                = fex_q;
  assign branch_PC_contral       = bc_q;
  assign branch_PC               = bpc_q;
  assign branch_PC_early_contral = bec_q;
  assign branch_PC_early         = bepc_q;
  assign csr_PC_contral          = cc_q;
  assign csr_PC                  = cspc_q;
  assign redirect_count          = cnt16_q;

endmodule
